// File: rtl/c_pipe_reg_if.sv
//------------------------------------------------------------------------------
// c_pipe_reg_if : push/pop valid-ready bus for the c_pipe_reg elastic pipeline
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface c_pipe_reg_if #(
  parameter int WIDTH = 32
);
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_ready;

  // Environment side: feeds the push end and consumes the pop end.
  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  // Pipeline side.
  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

`default_nettype wire

// File: rtl/c_pipe_reg.sv
//------------------------------------------------------------------------------
// c_pipe_reg : multi-stage elastic pipeline register with bubble collapsing,
//              global stall and occupancy count. Define C_PIPE_REG_SKID_EN to
//              add a registered-ready skid entry in front of stage 0.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module c_pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               COUNT_WIDTH = $clog2(DEPTH + 2)
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   active,
  c_pipe_reg_if.slave                 bus,
  output logic [COUNT_WIDTH-1:0]      count
);

  localparam logic [COUNT_WIDTH-1:0] c_one = COUNT_WIDTH'(1);

  logic [DEPTH-1:0]       r_v;
  logic [WIDTH-1:0]       r_d [DEPTH];
  logic [COUNT_WIDTH-1:0] r_count;
  logic [DEPTH:0]         w_rdy;
  logic                   w_push_rdy;
  logic                   w_push_fire;
  logic                   w_pop_fire;
  logic                   w_in_valid;
  logic [WIDTH-1:0]       w_in_data;

  // Ready ripples from the output back toward stage 0; an empty stage always accepts.
  always_comb begin
    logic w_chain;
    w_rdy        = '0;
    w_chain      = bus.pop_ready;
    w_rdy[DEPTH] = w_chain;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain  = ~r_v[i] | w_chain;
      w_rdy[i] = w_chain;
    end
  end

`ifdef C_PIPE_REG_SKID_EN
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;

  assign w_push_rdy  = ~r_skid_v & active;
  assign w_push_fire = bus.push_valid & w_push_rdy;
  // A held skid entry always goes to stage 0 before any new push.
  assign w_in_valid  = r_skid_v | w_push_fire;
  assign w_in_data   = r_skid_v ? r_skid_d : bus.push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_v <= 1'b0;
      r_skid_d <= RESET_VALUE;
    end else if (active) begin
      if (r_skid_v) begin
        if (w_rdy[0]) r_skid_v <= 1'b0;
      end else if (w_push_fire && !w_rdy[0]) begin
        r_skid_v <= 1'b1;
        r_skid_d <= bus.push_data;
      end
    end
  end
`else
  assign w_push_rdy  = w_rdy[0] & active;
  assign w_push_fire = bus.push_valid & w_push_rdy;
  assign w_in_valid  = w_push_fire;
  assign w_in_data   = bus.push_data;
`endif

  assign w_pop_fire = r_v[DEPTH-1] & bus.pop_ready & active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= RESET_VALUE;
    end else if (active) begin
      if (w_rdy[0]) begin
        r_v[0] <= w_in_valid;
        if (w_in_valid) r_d[0] <= w_in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) r_d[i] <= r_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (active) begin
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.push_ready = w_push_rdy;
  assign bus.pop_valid  = r_v[DEPTH-1] & active;
  assign bus.pop_data   = r_d[DEPTH-1];
  assign count          = r_count;

endmodule

`default_nettype wire

// File: tb/tb_c_pipe_reg.sv
//------------------------------------------------------------------------------
// tb_c_pipe_reg : directed self-checking bench for c_pipe_reg (DEPTH=3, WIDTH=8)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_c_pipe_reg;
  localparam int             WIDTH = 8;
  localparam int             DEPTH = 3;
  localparam logic [7:0]     RV    = 8'hA5;
  localparam int             CW    = $clog2(DEPTH + 2);
`ifdef C_PIPE_REG_SKID_EN
  localparam int             CAP   = DEPTH + 1;
`else
  localparam int             CAP   = DEPTH;
`endif

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          active = 1'b1;
  logic [CW-1:0] count;
  int            checks   = 0;
  int            failures = 0;

  c_pipe_reg_if #(.WIDTH(WIDTH)) bus ();

  c_pipe_reg #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .active(active),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [7:0] pd, input logic pr);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    active = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    checks++;
    if (bus.pop_valid !== 1'b0) begin
      failures++; $display("FAIL reset_pop_valid actual=%b required=0", bus.pop_valid);
    end
    checks++;
    if (bus.pop_data !== RV) begin
      failures++; $display("FAIL reset_pop_data actual=%h required=%h", bus.pop_data, RV);
    end
    checks++;
    if (count !== CW'(0)) begin
      failures++; $display("FAIL reset_count actual=%0d required=0", count);
    end
    checks++;
    if (bus.push_ready !== 1'b1) begin
      failures++; $display("FAIL reset_push_ready actual=%b required=1", bus.push_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h01 + k), 1'b1);
      tick();
      checks++;
      if ({bus.pop_valid, count} !== {(k == 2), CW'(k + 1)}) begin
        failures++;
        $display("FAIL lat_fill%0d actual=%b/%0d required=%b/%0d", k, bus.pop_valid, count, (k == 2), k + 1);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({bus.pop_valid, bus.pop_data, count} !== {1'b1, 8'(8'h01 + j), CW'(3 - j)}) begin
        failures++;
        $display("FAIL lat_pop%0d actual=%b/%h/%0d required=1/%h/%0d", j, bus.pop_valid, bus.pop_data, count, 8'(8'h01 + j), 3 - j);
      end
      tick();
    end
    checks++;
    if ({bus.pop_valid, count} !== {1'b0, CW'(0)}) begin
      failures++; $display("FAIL lat_empty actual=%b/%0d required=0/0", bus.pop_valid, count);
    end
  endtask

  task automatic test_fill();
    int   acc = 0;
    logic exp_rdy;
    for (int k = 0; k < CAP + 2; k++) begin
      drive(1'b1, 8'(8'h10 + acc), 1'b0);
      exp_rdy = (acc < CAP);
      checks++;
      if (bus.push_ready !== exp_rdy) begin
        failures++; $display("FAIL fill_ready%0d actual=%b required=%b", k, bus.push_ready, exp_rdy);
      end
      tick();
      if (exp_rdy) acc++;
      checks++;
      if (count !== CW'(acc)) begin
        failures++; $display("FAIL fill_count%0d actual=%0d required=%0d", k, count, acc);
      end
    end
    checks++;
    if ({bus.pop_valid, bus.pop_data} !== {1'b1, 8'h10}) begin
      failures++; $display("FAIL fill_head actual=%b/%h required=1/10", bus.pop_valid, bus.pop_data);
    end
`ifdef C_PIPE_REG_SKID_EN
    drive(1'b1, 8'(8'h10 + CAP), 1'b1);
    checks++;
    if (bus.push_ready !== 1'b0) begin
      failures++; $display("FAIL skid_ready actual=%b required=0", bus.push_ready);
    end
    tick();
    checks++;
    if (count !== CW'(DEPTH)) begin
      failures++; $display("FAIL skid_drain_count actual=%0d required=%0d", count, DEPTH);
    end
`endif
    drive(1'b1, 8'(8'h10 + CAP), 1'b1);
    checks++;
    if (bus.push_ready !== 1'b1) begin
      failures++; $display("FAIL simul_ready actual=%b required=1", bus.push_ready);
    end
    tick();
    checks++;
    if (count !== CW'(DEPTH)) begin
      failures++; $display("FAIL simul_count actual=%0d required=%0d", count, DEPTH);
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < DEPTH; j++) begin
      checks++;
      if ({bus.pop_valid, bus.pop_data} !== {1'b1, 8'(8'h10 + CAP - 2 + j)}) begin
        failures++;
        $display("FAIL fill_drain%0d actual=%b/%h required=1/%h", j, bus.pop_valid, bus.pop_data, 8'(8'h10 + CAP - 2 + j));
      end
      tick();
    end
    checks++;
    if ({bus.pop_valid, count} !== {1'b0, CW'(0)}) begin
      failures++; $display("FAIL fill_empty actual=%b/%0d required=0/0", bus.pop_valid, count);
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 8'hAA, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 8'hBB, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (5) tick();
    checks++;
    if ({bus.pop_valid, bus.pop_data, count} !== {1'b1, 8'hAA, CW'(2)}) begin
      failures++; $display("FAIL bubble_hold actual=%b/%h/%0d required=1/aa/2", bus.pop_valid, bus.pop_data, count);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++;
    if ({bus.pop_valid, bus.pop_data, count} !== {1'b1, 8'hBB, CW'(1)}) begin
      failures++; $display("FAIL bubble_second actual=%b/%h/%0d required=1/bb/1", bus.pop_valid, bus.pop_data, count);
    end
    tick();
    checks++;
    if ({bus.pop_valid, count} !== {1'b0, CW'(0)}) begin
      failures++; $display("FAIL bubble_empty actual=%b/%0d required=0/0", bus.pop_valid, count);
    end
  endtask

  task automatic test_active();
    for (int k = 0; k < CAP; k++) begin
      drive(1'b1, 8'(8'h30 + k), 1'b0);
      tick();
    end
    active = 1'b0;
    drive(1'b1, 8'h3F, 1'b1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.push_ready, bus.pop_valid, count, bus.pop_data} !== {1'b0, 1'b0, CW'(CAP), 8'h30}) begin
        failures++;
        $display("FAIL stall%0d actual=%b/%b/%0d/%h required=0/0/%0d/30", c, bus.push_ready, bus.pop_valid, count, bus.pop_data, CAP);
      end
      tick();
    end
    active = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < CAP; j++) begin
      checks++;
      if ({bus.pop_valid, bus.pop_data} !== {1'b1, 8'(8'h30 + j)}) begin
        failures++; $display("FAIL resume%0d actual=%b/%h required=1/%h", j, bus.pop_valid, bus.pop_data, 8'(8'h30 + j));
      end
      tick();
    end
    checks++;
    if ({bus.pop_valid, count} !== {1'b0, CW'(0)}) begin
      failures++; $display("FAIL resume_empty actual=%b/%0d required=0/0", bus.pop_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1'b1, 8'h40, 1'b0); tick();
    drive(1'b1, 8'h41, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    checks++;
    if ({bus.pop_valid, count} !== {1'b1, CW'(2)}) begin
      failures++; $display("FAIL pre_reset actual=%b/%0d required=1/2", bus.pop_valid, count);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.pop_valid, count, bus.pop_data} !== {1'b0, CW'(0), RV}) begin
      failures++; $display("FAIL async_reset actual=%b/%0d/%h required=0/0/a5", bus.pop_valid, count, bus.pop_data);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h50, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    n = 0;
    while (bus.pop_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if ({bus.pop_valid, bus.pop_data} !== {1'b1, 8'h50}) begin
      failures++; $display("FAIL post_reset_pop actual=%b/%h required=1/50", bus.pop_valid, bus.pop_data);
    end
    tick();
  endtask

  initial begin
    bus.push_valid = 1'b0;
    bus.push_data  = 8'h00;
    bus.pop_ready  = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_bubble();
    test_active();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
